// File: rtl/uart_ctrl.sv
// uart_ctrl: 16x-oversampled full-duplex UART with RX/TX FIFOs, runtime parity,
// sticky error flags and a loopback mode that forwards received words to TX.
module uart_ctrl_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr, r_rptr;
    logic         w_rd, w_wr;
    assign o_empty = r_wptr == r_rptr;
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge i_clk) if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
endmodule

module uart_ctrl #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_in,
    output logic                 o_tx_out,
    input  logic [DATA_BITS-1:0] i_tx_wdata,
    input  logic                 i_tx_push,
    output logic                 o_tx_full,
    output logic [DATA_BITS-1:0] o_rx_rdata,
    input  logic                 i_rx_pop,
    output logic                 o_rx_empty,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_loopback,
    input  logic                 i_err_clr,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW  = $clog2(DIV + 1);
    localparam int BW  = $clog2(DATA_BITS);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [TW-1:0]        r_tick_cnt;
    logic                 w_tick;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev, w_rx_fall;
    state_t               r_rx_state, w_rx_next, r_tx_state, w_tx_next;
    logic [3:0]           r_rx_tcnt, r_tx_tcnt;
    logic [BW-1:0]        r_rx_bcnt, r_tx_bcnt;
    logic [DATA_BITS-1:0] r_rx_shift, r_tx_shift, w_tx_head, w_tx_wdata;
    logic                 r_rx_pen, r_rx_podd, r_rx_perr, r_tx_pen, r_tx_par;
    logic                 w_rx_hit, w_rx_stop, w_rx_word, w_rx_full, w_rx_pop;
    logic                 w_tx_hit, w_tx_pop, w_tx_push, w_tx_empty, w_tx_out, w_lb_move;
    logic                 w_frame_evt, w_par_evt, w_ovr_evt;
    logic                 r_frame_err, r_parity_err, r_overrun;

    assign w_tick = r_tick_cnt == TW'(DIV - 1);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_rx_s1    <= i_rx_in;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
        end
    end

    // START samples mid-bit at tick 7; every later bit is 16 ticks on from there
    assign w_rx_fall = r_rx_prev && !r_rx_s2;
    assign w_rx_hit  = w_tick && (r_rx_tcnt == ((r_rx_state == S_START) ? 4'd7 : 4'd15));
    assign w_rx_stop = (r_rx_state == S_STOP) && w_rx_hit;
    assign w_rx_word = w_rx_stop && r_rx_s2;
    assign w_frame_evt = w_rx_stop && !r_rx_s2;
    assign w_par_evt   = w_rx_word && r_rx_perr;
    assign w_ovr_evt   = w_rx_word && w_rx_full && !w_rx_pop;

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:   if (w_rx_fall) w_rx_next = S_START;
            S_START:  if (w_rx_hit) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_hit && r_rx_bcnt == BW'(DATA_BITS - 1)) w_rx_next = r_rx_pen ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_hit) w_rx_next = S_STOP;
            S_STOP:   if (w_rx_hit) w_rx_next = S_IDLE;
            default:  w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state <= S_IDLE;
            r_rx_tcnt  <= '0;
            r_rx_bcnt  <= '0;
            r_rx_shift <= '0;
            r_rx_pen   <= 1'b0;
            r_rx_podd  <= 1'b0;
            r_rx_perr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_tcnt  <= (r_rx_state == S_IDLE || w_rx_hit) ? 4'd0 : r_rx_tcnt + {3'd0, w_tick};
            if (r_rx_state == S_IDLE && w_rx_fall) begin
                r_rx_pen  <= i_parity_en;
                r_rx_podd <= i_parity_odd;
                r_rx_perr <= 1'b0;
            end
            if (r_rx_state == S_START) r_rx_bcnt <= '0;
            if (r_rx_state == S_DATA && w_rx_hit) begin
                r_rx_bcnt  <= r_rx_bcnt + BW'(1);
                r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
            end
            if (r_rx_state == S_PARITY && w_rx_hit) r_rx_perr <= r_rx_s2 ^ (^r_rx_shift) ^ r_rx_podd;
        end
    end

    assign w_tx_hit = w_tick && (r_tx_tcnt == 4'd15);
    assign w_tx_pop = !w_tx_empty && w_tick && (r_tx_state == S_IDLE || (r_tx_state == S_STOP && r_tx_tcnt == 4'd15));
    assign o_tx_out = w_tx_out;

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_out  = 1'b1;
        case (r_tx_state)
            S_IDLE:   if (w_tx_pop) w_tx_next = S_START;
            S_START: begin
                w_tx_out = 1'b0;
                if (w_tx_hit) w_tx_next = S_DATA;
            end
            S_DATA: begin
                w_tx_out = r_tx_shift[0];
                if (w_tx_hit && r_tx_bcnt == BW'(DATA_BITS - 1)) w_tx_next = r_tx_pen ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                w_tx_out = r_tx_par;
                if (w_tx_hit) w_tx_next = S_STOP;
            end
            S_STOP:   if (w_tx_hit) w_tx_next = w_tx_pop ? S_START : S_IDLE;
            default:  w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state <= S_IDLE;
            r_tx_tcnt  <= '0;
            r_tx_bcnt  <= '0;
            r_tx_shift <= '0;
            r_tx_pen   <= 1'b0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_tcnt  <= (r_tx_state == S_IDLE || w_tx_hit) ? 4'd0 : r_tx_tcnt + {3'd0, w_tick};
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_bcnt  <= '0;
                r_tx_pen   <= i_parity_en;
                r_tx_par   <= (^w_tx_head) ^ i_parity_odd;
            end else if (r_tx_state == S_DATA && w_tx_hit) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_bcnt  <= r_tx_bcnt + BW'(1);
            end
        end
    end

    assign w_lb_move  = i_loopback && !o_rx_empty && !o_tx_full;
    assign w_rx_pop   = i_loopback ? w_lb_move : i_rx_pop;
    assign w_tx_push  = i_loopback ? w_lb_move : i_tx_push;
    assign w_tx_wdata = i_loopback ? o_rx_rdata : i_tx_wdata;

    uart_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_rx_word), .i_pop(w_rx_pop),
        .i_wdata(r_rx_shift), .o_rdata(o_rx_rdata), .o_full(w_rx_full), .o_empty(o_rx_empty)
    );
    uart_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_tx_push), .i_pop(w_tx_pop),
        .i_wdata(w_tx_wdata), .o_rdata(w_tx_head), .o_full(o_tx_full), .o_empty(w_tx_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_evt | (r_frame_err & ~i_err_clr);
            r_parity_err <= w_par_evt | (r_parity_err & ~i_err_clr);
            r_overrun    <= w_ovr_evt | (r_overrun & ~i_err_clr);
        end
    end
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: table-driven and randomized checks of uart_ctrl against a
// frame-level model (bit lists built from data, parity rule and stop value).
module tb_uart_ctrl;
    logic       clk = 0, rst_n = 0, rx_in = 1, tx_push = 0, rx_pop = 0;
    logic       pen = 0, podd = 0, lb = 0, clr = 0;
    logic [7:0] tx_wdata = 0;
    logic       tx_out, tx_full, rx_empty, fe, pe, ov;
    logic [7:0] rx_rdata;
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    uart_ctrl #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(8), .FIFO_DEPTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_in(rx_in), .o_tx_out(tx_out),
        .i_tx_wdata(tx_wdata), .i_tx_push(tx_push), .o_tx_full(tx_full),
        .o_rx_rdata(rx_rdata), .i_rx_pop(rx_pop), .o_rx_empty(rx_empty),
        .i_parity_en(pen), .i_parity_odd(podd), .i_loopback(lb), .i_err_clr(clr),
        .o_frame_err(fe), .o_parity_err(pe), .o_overrun(ov)
    );

    typedef struct {
        logic [7:0] d;
        logic p_en, p_odd, flip, stop, e_push, e_fe, e_pe;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as a bit list, index 0 = start bit; parity from the popcount rule.
    function automatic logic [15:0] frame(input logic [7:0] d, input logic p_en, p_odd, flip, stop);
        logic [15:0] f = '0;
        int n = p_en ? 11 : 10;
        f[8:1] = d;
        if (p_en) f[9] = logic'(($countones(d) + int'(p_odd)) % 2) ^ flip;
        f[n-1] = stop;
        return f;
    endfunction

    task automatic send(input logic [7:0] d, input logic p_en, p_odd, flip, stop);
        logic [15:0] f = frame(d, p_en, p_odd, flip, stop);
        int n = p_en ? 11 : 10;
        for (int i = 0; i < n; i++) begin
            rx_in = f[i];
            repeat (16) @(negedge clk);
        end
        rx_in = 1;
    endtask

    task automatic capture(input int n, output logic [15:0] got, output logic ok);
        int w = 0;
        got = '0;
        ok = 1;
        do begin
            @(negedge clk);
            w++;
        end while (tx_out !== 1'b0 && w < 3000);
        if (tx_out !== 1'b0) begin
            ok = 0;
            return;
        end
        for (int j = 0; j < 16 * n; j++) begin
            if (j > 0) @(negedge clk);
            if (j % 16 == 0) got[j/16] = tx_out;
            else if (tx_out !== got[j/16]) ok = 0;
        end
    endtask

    task automatic pulse_clr();
        clr = 1;
        @(negedge clk);
        clr = 0;
        @(negedge clk);
    endtask

    task automatic do_pop();
        rx_pop = 1;
        @(negedge clk);
        rx_pop = 0;
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[6];
        logic [15:0] got;
        logic        ok;
        logic [7:0]  q[$];
        logic [7:0]  lbd[3];
        logic        exp_ov;
        int          lows;

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        lbd[0] = 8'h11; lbd[1] = 8'h22; lbd[2] = 8'h33;

        repeat (3) @(negedge clk);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_rdata", rx_rdata, 0);
        chk("rst_flags", {fe, pe, ov}, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_tx_out", tx_out, 1);
        chk("post_rst_rx_empty", rx_empty, 1);

        for (int i = 0; i < 6; i++) begin
            pen = tbl[i].p_en;
            podd = tbl[i].p_odd;
            send(tbl[i].d, tbl[i].p_en, tbl[i].p_odd, tbl[i].flip, tbl[i].stop);
            repeat (4) @(negedge clk);
            chk($sformatf("tbl%0d_empty", i), rx_empty, !tbl[i].e_push);
            chk($sformatf("tbl%0d_rdata", i), rx_rdata, tbl[i].e_push ? tbl[i].d : 8'h00);
            chk($sformatf("tbl%0d_frame_err", i), fe, tbl[i].e_fe);
            chk($sformatf("tbl%0d_parity_err", i), pe, tbl[i].e_pe);
            chk($sformatf("tbl%0d_overrun", i), ov, 0);
            if (tbl[i].e_push) do_pop();
            @(negedge clk);
            chk($sformatf("tbl%0d_popped", i), rx_empty, 1);
            pulse_clr();
            chk($sformatf("tbl%0d_clr", i), {fe, pe, ov}, 0);
        end

        pen = 0;
        rx_in = 0;
        repeat (4) @(negedge clk);
        rx_in = 1;
        repeat (40) @(negedge clk);
        chk("false_start_empty", rx_empty, 1);
        chk("false_start_fe", fe, 0);

        pen = 1; podd = 0;
        tx_wdata = 8'h07; tx_push = 1;
        @(negedge clk);
        tx_push = 0;
        capture(11, got, ok);
        chk("tx07_timing", ok, 1);
        chk("tx07_bits", got, 16'h060E);
        repeat (4) @(negedge clk);
        chk("tx07_idle", tx_out, 1);

        pen = 0; podd = 0; exp_ov = 0;
        for (int i = 0; i < 9; i++) begin
            send(8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
            if (q.size() < 8) q.push_back(8'(i));
            else exp_ov = 1;
        end
        repeat (4) @(negedge clk);
        chk("ovr_flag", ov, exp_ov);
        chk("ovr_tx_full", tx_full, 0);
        while (q.size() > 0) begin
            chk("ovr_rdata", rx_rdata, q.pop_front());
            do_pop();
        end
        chk("ovr_drained", rx_empty, 1);
        pulse_clr();

        lb = 1;
        fork
            for (int i = 0; i < 3; i++) send(lbd[i], 1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) begin
                logic [15:0] g;
                logic        k;
                capture(10, g, k);
                chk($sformatf("lb%0d_timing", i), k, 1);
                chk($sformatf("lb%0d_bits", i), g, frame(lbd[i], 1'b0, 1'b0, 1'b0, 1'b1));
            end
            begin
                repeat (200) @(negedge clk);
                tx_wdata = 8'hEE; tx_push = 1;
                @(negedge clk);
                tx_push = 0;
            end
        join
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_out === 1'b0) lows++;
        end
        chk("lb_no_extra_tx", lows, 0);
        chk("lb_rx_empty", rx_empty, 1);
        lb = 0;

        for (int i = 0; i < 12; i++) begin
            logic [7:0] d = 8'($urandom);
            logic p_en = 1'($urandom), p_odd = 1'($urandom);
            logic flip = ($urandom_range(3) == 0), stop = ($urandom_range(5) != 0);
            pen = p_en; podd = p_odd;
            send(d, p_en, p_odd, flip, stop);
            repeat (4) @(negedge clk);
            chk($sformatf("rnd_rx%0d_empty", i), rx_empty, !stop);
            chk($sformatf("rnd_rx%0d_rdata", i), rx_rdata, stop ? d : 8'h00);
            chk($sformatf("rnd_rx%0d_fe", i), fe, !stop);
            chk($sformatf("rnd_rx%0d_pe", i), pe, stop && p_en && flip);
            if (stop) do_pop();
            pulse_clr();
        end

        for (int i = 0; i < 12; i++) begin
            logic [7:0] d = 8'($urandom);
            logic p_en = 1'($urandom), p_odd = 1'($urandom);
            pen = p_en; podd = p_odd;
            tx_wdata = d; tx_push = 1;
            @(negedge clk);
            tx_push = 0;
            fork
                capture(p_en ? 11 : 10, got, ok);
                begin
                    repeat (50) @(negedge clk);
                    pen = ~pen; podd = ~podd;
                end
            join
            chk($sformatf("rnd_tx%0d_timing", i), ok, 1);
            chk($sformatf("rnd_tx%0d_bits", i), got, frame(d, p_en, p_odd, 1'b0, 1'b1));
            repeat (2) @(negedge clk);
        end

        pen = 0; podd = 0;
        tx_wdata = 8'h00; tx_push = 1;
        @(negedge clk);
        tx_wdata = 8'h55;
        @(negedge clk);
        tx_push = 0;
        lows = 0;
        while (tx_out !== 1'b0 && lows < 3000) begin
            @(negedge clk);
            lows++;
        end
        chk("rst_tx_started", tx_out, 0);
        repeat (16 * 4 + 8) @(negedge clk);
        chk("rst_tx_bit3", tx_out, 0);
        rst_n = 0;
        #1;
        chk("rst_async_tx_out", tx_out, 1);
        chk("rst_async_tx_full", tx_full, 0);
        chk("rst_async_rx_empty", rx_empty, 1);
        repeat (3) @(negedge clk);
        rst_n = 1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_out === 1'b0) lows++;
        end
        chk("rst_no_residual", lows, 0);
        chk("rst_rx_still_empty", rx_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
